// File: rtl/banco_datos_param.sv
// banco_datos_param: multi-bank word memory with byte-masked writes and a
// one-cycle registered read port. After reset an INIT sweep zeroes every
// address of every bank; Ready is held low until the sweep completes.
//
// Ports:
//   CLK          sole clock, rising edge
//   RST          synchronous active-high reset
//   Eneable      request valid
//   WriteEneable 1 = write, 0 = read (sampled with Eneable)
//   Sel_Mem      target bank
//   Address      word address within the bank
//   Data         write data
//   ByteEn       per-byte write mask, bit i covers Data[8i+7:8i]
//   Ready        request accepted this cycle when Eneable=1
//   LineData     registered read data, holds until the next read result
//   DataValid    one-cycle pulse marking a new LineData
module banco_datos_param #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned SEL_W     = $clog2(NUM_BANKS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Eneable,
    input  logic                WriteEneable,
    input  logic [SEL_W-1:0]    Sel_Mem,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   Data,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic                Ready,
    output logic [DATA_W-1:0]   LineData,
    output logic                DataValid
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NBYTE = DATA_W / 8;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   line_q;
    logic                valid_q;
    logic [DATA_W-1:0]   mem_q [NUM_BANKS][DEPTH];

    logic accept;
    logic wr_acc;
    logic rd_acc;

    // Gating with RST keeps the outputs quiet during the first reset cycle,
    // before the synchronous reset has reached the registers.
    assign Ready     = (state_q == StRun) && !RST;
    assign DataValid = valid_q && !RST;
    assign LineData  = RST ? '0 : line_q;

    assign accept = Eneable && Ready;
    assign wr_acc = accept && WriteEneable;
    assign rd_acc = accept && !WriteEneable;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StInit: begin
                // Counter parks at the last address; it never wraps.
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = StRun;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StInit;
            clr_addr_q <= '0;
            line_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            valid_q    <= rd_acc;
            // Bank and address are consumed at acceptance, so later changes
            // to Sel_Mem cannot disturb the returned word.
            if (rd_acc) begin
                line_q <= mem_q[Sel_Mem][Address];
            end
        end
    end

    // Storage has no reset; contents become defined by the INIT sweep.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == StInit) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    mem_q[b][clr_addr_q] <= '0;
                end
            end else if (wr_acc) begin
                for (int i = 0; i < NBYTE; i++) begin
                    if (ByteEn[i]) begin
                        mem_q[Sel_Mem][Address][8*i +: 8] <= Data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_banco_datos_param.sv
module tb_banco_datos_param;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NBANK  = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              Eneable = 1'b0;
    logic              WriteEneable = 1'b0;
    logic [1:0]        Sel_Mem = '0;
    logic [ADDR_W-1:0] Address = '0;
    logic [DATA_W-1:0] Data = '0;
    logic [7:0]        ByteEn = '0;
    logic              Ready;
    logic [DATA_W-1:0] LineData;
    logic              DataValid;

    banco_datos_param #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_BANKS(NBANK)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Eneable     (Eneable),
        .WriteEneable(WriteEneable),
        .Sel_Mem     (Sel_Mem),
        .Address     (Address),
        .Data        (Data),
        .ByteEn      (ByteEn),
        .Ready       (Ready),
        .LineData    (LineData),
        .DataValid   (DataValid)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model [NBANK][16];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_line = '0;
    bit                run_mode  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every DataValid pops one expected word; otherwise LineData must hold.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge CLK);
            if (DataValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data", LineData, e);
                    last_line = e;
                end
            end else begin
                chk("line_hold", LineData, last_line);
            end
            if (run_mode) chk("ready_run", {63'd0, Ready}, 64'd1);
        end
    end

    task automatic clear_model();
        for (int b = 0; b < NBANK; b++)
            for (int a = 0; a < 16; a++)
                model[b][a] = '0;
    endtask

    // Entered and left at negedge+1.
    task automatic pulse_reset();
        RST      = 1'b1;
        Eneable  = 1'b0;
        run_mode = 1'b0;
        exp_q.delete();
        last_line = '0;
        clear_model();
        @(negedge CLK);
        #1;
        chk("rst_ready", {63'd0, Ready}, 64'd0);
        chk("rst_valid", {63'd0, DataValid}, 64'd0);
        chk("rst_line", LineData, 64'd0);
    endtask

    // Releases reset and counts Ready=0 cycles; optionally fires a write mid-sweep.
    task automatic wait_init(input bit inject);
        int n;
        n = 0;
        RST = 1'b0;
        #1;
        while (!Ready && n < 100) begin
            if (inject && n == 3) begin
                Eneable      = 1'b1;
                WriteEneable = 1'b1;
                Sel_Mem      = 2'd2;
                Address      = 4'd3;
                Data         = 64'hDEAD_BEEF_CAFE_F00D;
                ByteEn       = 8'hFF;
            end else begin
                Eneable = 1'b0;
            end
            n++;
            @(negedge CLK);
            #1;
        end
        Eneable = 1'b0;
        chk("init_len", 64'(n), 64'd16);
        run_mode = 1'b1;
    endtask

    task automatic issue(input logic we, input logic [1:0] bank, input logic [3:0] addr,
                         input logic [63:0] d, input logic [7:0] be);
        Eneable      = 1'b1;
        WriteEneable = we;
        Sel_Mem      = bank;
        Address      = addr;
        Data         = d;
        ByteEn       = be;
        if (run_mode) begin
            if (we) begin
                for (int i = 0; i < 8; i++)
                    if (be[i]) model[bank][addr][8*i +: 8] = d[8*i +: 8];
            end else begin
                exp_q.push_back(model[bank][addr]);
            end
        end
        @(negedge CLK);
        #1;
        Eneable = 1'b0;
        Sel_Mem = ~bank;
        Address = ~addr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            Eneable = 1'b0;
            @(negedge CLK);
            #1;
        end
    endtask

    initial begin
        @(negedge CLK);
        #1;
        pulse_reset();
        wait_init(1'b0);

        issue(1'b0, 2'd3, 4'd15, 64'd0, 8'h00);
        idle(1);

        issue(1'b1, 2'd1, 4'd5, 64'h1122334455667788, 8'hFF);
        issue(1'b0, 2'd1, 4'd5, 64'd0, 8'h00);
        issue(1'b0, 2'd2, 4'd5, 64'd0, 8'h00);
        issue(1'b1, 2'd1, 4'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        issue(1'b0, 2'd1, 4'd5, 64'd0, 8'h00);
        idle(2);

        for (int b = 0; b < 4; b++) issue(1'b1, 2'(b), 4'd7, 64'(b + 1), 8'hFF);
        for (int b = 0; b < 4; b++) issue(1'b0, 2'(b), 4'd7, 64'd0, 8'h00);
        idle(3);

        // Reset mid-sweep at clr address 9, then a write attempted during INIT.
        issue(1'b1, 2'd0, 4'd2, 64'h0123456789ABCDEF, 8'hFF);
        pulse_reset();
        RST = 1'b0;
        repeat (9) @(negedge CLK);
        #1;
        pulse_reset();
        wait_init(1'b1);
        issue(1'b0, 2'd0, 4'd2, 64'd0, 8'h00);
        issue(1'b0, 2'd1, 4'd5, 64'd0, 8'h00);
        issue(1'b0, 2'd2, 4'd3, 64'd0, 8'h00);
        idle(2);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
            end else begin
                idle(1);
            end
        end
        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banco_datos_param.md
BANCO_DATOS_PARAM -- requirements
Module: banco_datos_param

Interface
REQ-001 Parameter DATA_W, default 64, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 11, per-bank word address width; depth = 2^ADDR_W.
REQ-003 Parameter NUM_BANKS, default 4, bank count; SHALL be a power of two, >= 2.
REQ-004 Parameter SEL_W, default $clog2(NUM_BANKS), bank-select width.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 Eneable  input  1  request valid, active-high.
REQ-008 WriteEneable  input  1  1 = write request, 0 = read request; sampled with Eneable.
REQ-009 Sel_Mem  input  SEL_W  target bank.
REQ-010 Address  input  ADDR_W  word address within the bank.
REQ-011 Data  input  DATA_W  write data.
REQ-012 ByteEn  input  DATA_W/8  per-byte write mask, bit i covers Data[8i+7:8i].
REQ-013 Ready  output  1  block accepts a request this cycle.
REQ-014 LineData  output  DATA_W  registered read data.
REQ-015 DataValid  output  1  one-cycle pulse; LineData carries a new read result.

Function
REQ-016 Storage SHALL be NUM_BANKS independent arrays of 2^ADDR_W x DATA_W words.
REQ-017 A request SHALL be accepted only on a cycle with Eneable=1 and Ready=1; requests seen while Ready=0 SHALL be ignored, with no side effect.
REQ-018 Accepted write: at the same edge, bytes of word [Sel_Mem][Address] with ByteEn=1 SHALL take Data; bytes with ByteEn=0 and all other banks SHALL be unchanged.
REQ-019 Accepted write SHALL NOT pulse DataValid and SHALL NOT change LineData.
REQ-020 Accepted read: at the next rising edge, LineData = word [Sel_Mem][Address] as stored before that edge, and DataValid = 1 for exactly one cycle. Latency is 1 cycle.
REQ-021 Bank selection for the output mux SHALL be registered with the request; changes to Sel_Mem after acceptance SHALL NOT change LineData.
REQ-022 LineData SHALL hold its last value until the next read result; DataValid=0 in all cycles without a new result.
REQ-023 Back-to-back reads on consecutive cycles SHALL be supported, one result per cycle, in order.
REQ-024 A read in the cycle immediately after a write to the same bank/address SHALL return the newly written bytes.
REQ-025 FSM states: INIT, RUN.
REQ-026 INIT: sweep counter clr_addr runs 0 .. 2^ADDR_W-1, one address per cycle, writing zero to that address in all banks in parallel; Ready=0.
REQ-027 INIT -> RUN on the cycle after clr_addr = 2^ADDR_W-1 is written; counter SHALL NOT wrap or repeat.
REQ-028 RUN: Ready=1 every cycle; stays in RUN until RST.
REQ-029 INIT duration SHALL be exactly 2^ADDR_W cycles from RST deassertion to first Ready=1 cycle.

Reset
REQ-030 While RST=1: state = INIT, clr_addr = 0, Ready = 0, DataValid = 0, LineData = 0; requests ignored.
REQ-031 RST asserted mid-sweep or mid-read SHALL restart the sweep from address 0 and cancel any pending DataValid pulse.
REQ-032 Array contents are not reset directly; they are defined only after the INIT sweep completes.

Verification
REQ-033 Defaults except ADDR_W=4: pulse RST 1 cycle -> Ready=0 for exactly 16 cycles, then 1; read bank 3 addr 15 -> LineData=0, DataValid=1 one cycle later.
REQ-034 Write bank 1 addr 5 Data=64'h1122334455667788 ByteEn=8'hFF, then read bank 1 addr 5 next cycle -> LineData=64'h1122334455667788; read bank 2 addr 5 -> 0.
REQ-035 Over REQ-034 word, write Data=64'hAAAAAAAAAAAAAAAA ByteEn=8'h0F, read -> LineData=64'h11223344AAAAAAAA.
REQ-036 Reads on 4 consecutive cycles to banks 0,1,2,3 addr 7 (preloaded 1,2,3,4) -> DataValid high 4 cycles, LineData 1,2,3,4 in order; Sel_Mem toggled after each acceptance does not alter results.
REQ-037 RST asserted at sweep address 9, then released -> Ready=0 for a full 16 cycles; previously written data reads as 0.
REQ-038 Eneable=1 write during INIT -> ignored; after RUN, target word reads 0.
